// File: rtl/div_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_controller_pkg                                                   |
// | Shared state encoding and sizing helpers for the divider controller. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package div_controller_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } divState_e;

  // Step counter must be able to represent WIDTH itself.
  function automatic int cntWidth(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DEFAULT_CNT_WIDTH = cntWidth(DEFAULT_WIDTH);

endpackage
`default_nettype wire

// File: rtl/div_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_controller_if                                                    |
// | Request/result bundle between a requester and the divider.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface div_controller_if
  import div_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             isDiv;
  logic             isMod;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, A, B, isDiv, isMod, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, A, B, isDiv, isMod, flush,
    output busy, done, result
  );

endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_step                                                             |
// | One unsigned restoring-division step (combinational).                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_step #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0] i_remainder,
  input  wire logic             i_dividendMsb,
  input  wire logic [WIDTH-1:0] i_divisor,
  output logic      [WIDTH-1:0] o_remainder,
  output logic                  o_quotientBit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  assign w_shifted = {i_remainder, i_dividendMsb};
  // Remainder < divisor, so the shifted value is < 2*divisor and the
  // borrow bit alone tells whether the subtraction succeeds.
  assign w_trial       = w_shifted - {1'b0, i_divisor};
  assign o_quotientBit = ~w_trial[WIDTH];
  assign o_remainder   = o_quotientBit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/div_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_controller                                                       |
// | Sequential unsigned divider: one quotient bit per cycle, MSB first.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_controller
  import div_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input wire logic        clk,
  input wire logic        reset,
  div_controller_if.slave bus
);

  localparam int                CNT_W      = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] c_lastStep = CNT_W'(WIDTH - 1);

  divState_e        r_state;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_remainder;
  logic             r_isDiv;
  logic             r_isMod;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH-1:0] w_stepRem;
  logic             w_qBit;
  logic [WIDTH-1:0] w_quotient;

  div_step #(
    .WIDTH(WIDTH)
  ) u_divStep (
    .i_remainder  (r_remainder),
    .i_dividendMsb(r_dividend[WIDTH-1]),
    .i_divisor    (r_divisor),
    .o_remainder  (w_stepRem),
    .o_quotientBit(w_qBit)
  );

  // Quotient bits shift into the dividend register as its bits shift out.
  assign w_quotient = {r_dividend[WIDTH-2:0], w_qBit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_remainder <= '0;
      r_isDiv     <= 1'b0;
      r_isMod     <= 1'b0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_dividend  <= bus.A;
            r_divisor   <= bus.B;
            r_isDiv     <= bus.isDiv;
            r_isMod     <= bus.isMod;
            r_remainder <= '0;
            r_count     <= '0;
            r_busy      <= 1'b1;
            if ((bus.B == '0) || (!bus.isDiv && !bus.isMod)) begin
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_result <= '0;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_remainder <= w_stepRem;
            r_dividend  <= w_quotient;
            r_count     <= r_count + CNT_W'(1);
            if (r_count == c_lastStep) begin
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_result <= r_isDiv ? w_quotient : (r_isMod ? w_stepRem : '0);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_controller                                                    |
// | Directed table-driven bench for div_controller plus corner sequences.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_div_controller;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  div_controller_if #(.WIDTH(W)) bus();

  div_controller #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         isDiv;
    logic         isMod;
    logic [W-1:0] expResult;
    int           expLatency;
  } vec_t;

  vec_t         vecs[$];
  int           total = 0;
  int           bad   = 0;

  logic [W-1:0] res;
  int           lat;
  bit           sawDone;
  bit           busyDropped;
  bit           pulseLong;
  int           doneCount;
  int           firstLat;
  bit           busyLow;
  logic [W-1:0] firstRes;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request and waits (bounded) for its done pulse.
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic d, input logic m, input bit alignedNow,
                       output logic [W-1:0] r, output int l, output bit seen,
                       output bit dropped, output bit longPulse);
    if (!alignedNow) @(negedge clk);
    bus.A = a; bus.B = b; bus.isDiv = d; bus.isMod = m; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    l = 1;
    dropped = 1'b0;
    while (!bus.done && l < 100) begin
      if (!bus.busy) dropped = 1'b1;
      @(posedge clk); #1;
      l++;
    end
    seen = bus.done;
    r    = bus.result;
    @(posedge clk); #1;
    longPulse = bus.done || bus.busy;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0;
    bus.A = '0; bus.B = '0; bus.isDiv = 1'b0; bus.isMod = 1'b0;

    vecs.push_back('{32'd100,        32'd5,        1'b1, 1'b0, 32'h0000_0014, 33});
    vecs.push_back('{32'd100,        32'd7,        1'b0, 1'b1, 32'h0000_0002, 33});
    vecs.push_back('{32'd49,         32'd5,        1'b1, 1'b1, 32'h0000_0009, 33});
    vecs.push_back('{32'd1234,       32'd0,        1'b1, 1'b0, 32'h0000_0000, 1});
    vecs.push_back('{32'd55,         32'd9,        1'b0, 1'b0, 32'h0000_0000, 1});
    vecs.push_back('{32'hFFFF_FFFE,  32'h0000_FFFF, 1'b1, 1'b0, 32'h0001_0000, 33});
    vecs.push_back('{32'hFFFF_FFFE,  32'h0000_FFFF, 1'b0, 1'b1, 32'h0000_FFFE, 33});
    vecs.push_back('{32'd7,          32'd9,        1'b1, 1'b0, 32'h0000_0000, 33});
    vecs.push_back('{32'd7,          32'd9,        1'b0, 1'b1, 32'h0000_0007, 33});
    vecs.push_back('{32'hFFFF_FFFF,  32'd1,        1'b1, 1'b0, 32'hFFFF_FFFF, 33});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 33});
    vecs.push_back('{32'd1000,       32'd0,        1'b0, 1'b1, 32'h0000_0000, 1});

    repeat (3) @(posedge clk);
    #1;
    check("reset busy",   {31'b0, bus.busy}, 32'd0);
    check("reset done",   {31'b0, bus.done}, 32'd0);
    check("reset result", bus.result,        32'd0);

    // First request is presented in the same step reset drops.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      runOp(vecs[i].a, vecs[i].b, vecs[i].isDiv, vecs[i].isMod, (i == 0),
            res, lat, sawDone, busyDropped, pulseLong);
      check($sformatf("vec%0d done seen", i),   {31'b0, sawDone},     32'd1);
      check($sformatf("vec%0d result", i),      res,                  vecs[i].expResult);
      check($sformatf("vec%0d latency", i),     lat,                  vecs[i].expLatency);
      check($sformatf("vec%0d busy held", i),   {31'b0, busyDropped}, 32'd0);
      check($sformatf("vec%0d pulse end", i),   {31'b0, pulseLong},   32'd0);
      check($sformatf("vec%0d result hold", i), bus.result,           vecs[i].expResult);
    end

    // Extra starts while busy in CALC (edge 10) and in the DONE cycle (edge 34).
    doneCount = 0; firstLat = 0; busyLow = 1'b0; firstRes = '0;
    @(negedge clk);
    bus.A = 32'd100; bus.B = 32'd5; bus.isDiv = 1'b1; bus.isMod = 1'b0; bus.start = 1'b1;
    for (int e = 1; e <= 75; e++) begin
      if (e == 10 || e == 34) begin
        @(negedge clk);
        bus.A = 32'd1; bus.B = 32'd1; bus.isDiv = 1'b0; bus.isMod = 1'b1; bus.start = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        doneCount++;
        if (doneCount == 1) begin
          firstLat = e;
          firstRes = bus.result;
        end
      end
      if (e <= 33 && !bus.busy) busyLow = 1'b1;
      if (e == 34) check("start in DONE ignored", {31'b0, bus.busy}, 32'd0);
    end
    check("busy start done count", doneCount,        32'd1);
    check("busy start latency",    firstLat,         32'd33);
    check("busy start result",     firstRes,         32'd20);
    check("busy start busy held",  {31'b0, busyLow}, 32'd0);
    check("busy start result hold", bus.result,      32'd20);

    // Flush mid-calculation.
    @(negedge clk);
    bus.A = 32'd100; bus.B = 32'd7; bus.isDiv = 1'b1; bus.isMod = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush busy",   {31'b0, bus.busy}, 32'd0);
    check("flush done",   {31'b0, bus.done}, 32'd0);
    check("flush result", bus.result,        32'd20);
    doneCount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) doneCount++;
    end
    check("flush no done", doneCount, 32'd0);
    runOp(32'd100, 32'd7, 1'b1, 1'b0, 1'b0, res, lat, sawDone, busyDropped, pulseLong);
    check("after flush result",  res, 32'd14);
    check("after flush latency", lat, 32'd33);

    // Asynchronous reset mid-calculation.
    @(negedge clk);
    bus.A = 32'd100; bus.B = 32'd5; bus.isDiv = 1'b0; bus.isMod = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async reset busy",   {31'b0, bus.busy}, 32'd0);
    check("async reset done",   {31'b0, bus.done}, 32'd0);
    check("async reset result", bus.result,        32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    doneCount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) doneCount++;
    end
    check("reset no done", doneCount, 32'd0);
    runOp(32'd49, 32'd5, 1'b0, 1'b1, 1'b0, res, lat, sawDone, busyDropped, pulseLong);
    check("after reset result",  res, 32'd4);
    check("after reset latency", lat, 32'd33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
